// File: rtl/rr_mux_arb.sv
// rr_mux_arb: NCH-to-1 valid/ready channel mux with round-robin or fixed-priority arbitration and a manual-select override.
// Latency: 1 cycle from input acceptance to out_valid. Throughput is 1 item/cycle while out_ready=1.
// Backpressure: when the output register holds an item that is not drained, all in_ready go low and the outputs hold.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_data/in_valid     NCH producer channels; channel i is in_data[i*WIDTH +: WIDTH]
//   in_ready             per-channel ready; combinational, at most one bit set
//   out_data/out_valid   registered output item toward the consumer
//   out_ready            consumer ready
//   out_sel              registered index of the channel that sourced out_data
//   force_en/force_sel   manual select override; acts on the same-cycle grant
module rr_mux_arb #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int MODE  = 0,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel,
    input  logic                 force_en,
    input  logic [SELW-1:0]      force_sel
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [NCH-1:0]   grant;

    // Output register can take a new item when empty or being drained this cycle.
    assign load_en = !valid_q || out_ready;

    // Grant search. The forced path compares against each legal index rather than
    // indexing in_valid with force_sel, so an out-of-range select simply finds nothing.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (force_en) begin
            for (int i = 0; i < NCH; i++) begin
                if (!gnt_any && force_sel == SELW'(i) && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else if (MODE == 1) begin
            for (int i = 0; i < NCH; i++) begin
                if (!gnt_any && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            // Search ptr, ptr+1, ... with wrap-around.
            for (int k = 0; k < NCH; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (!gnt_any && in_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(idx);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NCH; i++) begin
            grant[i] = gnt_any && (gnt_idx == SELW'(i));
        end
    end

    // Gated by rst_n so no producer sees a handshake while the block is held in reset.
    assign in_ready = (rst_n && load_en) ? grant : '0;

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (gnt_any) begin
                data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
                sel_d   = gnt_idx;
                valid_d = 1'b1;
                // Forced transfers leave the fairness pointer alone so arbitration
                // resumes where it left off once the override is released.
                if (MODE == 0 && !force_en) begin
                    ptr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + SELW'(1);
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
module tb_rr_mux_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;
    logic        force_en;
    logic [1:0]  force_sel;

    logic [3:0]  rr_in_ready, fp_in_ready;
    logic [3:0]  rr_out_data, fp_out_data;
    logic        rr_out_valid, fp_out_valid;
    logic [1:0]  rr_out_sel, fp_out_sel;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rr_mux_arb #(.WIDTH(4), .NCH(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rr_in_ready),
        .out_data(rr_out_data), .out_valid(rr_out_valid), .out_ready(out_ready),
        .out_sel(rr_out_sel), .force_en(force_en), .force_sel(force_sel)
    );

    rr_mux_arb #(.WIDTH(4), .NCH(4), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(fp_in_ready),
        .out_data(fp_out_data), .out_valid(fp_out_valid), .out_ready(out_ready),
        .out_sel(fp_out_sel), .force_en(force_en), .force_sel(force_sel)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rr(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
        chk({tag, "_valid"}, 16'(rr_out_valid), 16'(v));
        chk({tag, "_data"},  16'(rr_out_data),  16'(d));
        chk({tag, "_sel"},   16'(rr_out_sel),   16'(s));
    endtask

    logic [3:0] exp_d [6];
    logic [1:0] exp_s [6];

    initial begin
        exp_d = '{4'h5, 4'hA, 4'h3, 4'hC, 4'h5, 4'hA};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_n     = 1'b0;
        in_data   = 16'h0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        force_en  = 1'b0;
        force_sel = 2'd0;
        tick(); tick();
        chk_rr("rst", 1'b0, 4'h0, 2'd0);
        chk("rst_in_ready", 16'(rr_in_ready), 16'h0);

        // Reset mid-transfer
        rst_n    = 1'b1;
        in_valid = 4'b0010;
        in_data  = 16'h0070;
        #1;
        chk("ld_in_ready", 16'(rr_in_ready), 16'b0010);
        tick();
        chk_rr("ld", 1'b1, 4'h7, 2'd1);
        chk("hold_in_ready", 16'(rr_in_ready), 16'h0);
        in_valid = 4'b0000;
        rst_n    = 1'b0;
        #1;
        chk_rr("midrst", 1'b0, 4'h0, 2'd0);
        tick();
        rst_n    = 1'b1;
        in_data  = 16'h5070;
        in_valid = 4'b1010;
        #1;
        chk("ptr_reset", 16'(rr_in_ready), 16'b0010);
        in_valid = 4'b1000;
        #1;
        chk("ch3_first", 16'(rr_in_ready), 16'b1000);
        tick();
        chk_rr("ch3_out", 1'b1, 4'h5, 2'd3);

        // Single channel
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        in_data   = 16'h0A00;
        #1;
        chk("single_rdy", 16'(rr_in_ready), 16'b0100);
        tick();
        chk_rr("single", 1'b1, 4'hA, 2'd2);
        in_valid = 4'b0000;
        #1;
        chk("idle_rdy", 16'(rr_in_ready), 16'h0);
        tick();
        chk_rr("drain", 1'b0, 4'hA, 2'd2);

        // Round-robin fairness (first bring ptr back to 0 via ch3)
        in_data  = 16'hC3A5;
        in_valid = 4'b1000;
        #1;
        chk("pre_rdy", 16'(rr_in_ready), 16'b1000);
        tick();
        chk_rr("pre", 1'b1, 4'hC, 2'd3);
        in_valid = 4'b1111;
        #1;
        chk("rr_rdy0", 16'(rr_in_ready), 16'b0001);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk_rr($sformatf("rr%0d", j), 1'b1, exp_d[j], exp_s[j]);
        end

        // Backpressure while out_data=A
        out_ready = 1'b0;
        #1;
        chk("bp_rdy", 16'(rr_in_ready), 16'h0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk_rr($sformatf("bp%0d", j), 1'b1, 4'hA, 2'd1);
            chk($sformatf("bp%0d_rdy", j), 16'(rr_in_ready), 16'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 16'(rr_in_ready), 16'b0100);
        tick();
        chk_rr("bp_rel0", 1'b1, 4'h3, 2'd2);
        tick();
        chk_rr("bp_rel1", 1'b1, 4'hC, 2'd3);

        // Force mode: first move ptr to 2 with a ch1 transfer
        in_data  = 16'hA035;
        in_valid = 4'b0010;
        #1;
        chk("f_pre_rdy", 16'(rr_in_ready), 16'b0010);
        tick();
        chk_rr("f_pre", 1'b1, 4'h3, 2'd1);
        force_en = 1'b1;
        in_valid = 4'b1001;
        for (int j = 0; j < 10; j++) begin
            force_sel = (j < 5) ? 2'd0 : 2'd3;
            #1;
            chk($sformatf("f%0d_rdy", j), 16'(rr_in_ready), (j < 5) ? 16'b0001 : 16'b1000);
            tick();
            chk_rr($sformatf("f%0d", j), 1'b1, (j < 5) ? 4'h5 : 4'hA, (j < 5) ? 2'd0 : 2'd3);
        end
        force_sel = 2'd1;
        #1;
        chk("f_inv_rdy", 16'(rr_in_ready), 16'h0);
        tick();
        chk_rr("f_inv", 1'b0, 4'hA, 2'd3);
        force_en = 1'b0;
        #1;
        chk("f_resume_rdy", 16'(rr_in_ready), 16'b1000);
        tick();
        chk_rr("f_resume", 1'b1, 4'hA, 2'd3);
        chk("f_next_rdy", 16'(rr_in_ready), 16'b0001);
        tick();
        chk_rr("f_next", 1'b1, 4'h5, 2'd0);

        // Fixed priority instance
        in_data  = 16'h4090;
        in_valid = 4'b1010;
        #1;
        chk("fp_rdy", 16'(fp_in_ready), 16'b0010);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("fp%0d_valid", j), 16'(fp_out_valid), 16'h1);
            chk($sformatf("fp%0d_data", j),  16'(fp_out_data),  16'h9);
            chk($sformatf("fp%0d_sel", j),   16'(fp_out_sel),   16'h1);
            chk($sformatf("fp%0d_rdy", j),   16'(fp_in_ready),  16'b0010);
        end
        in_valid = 4'b1000;
        #1;
        chk("fp_drop_rdy", 16'(fp_in_ready), 16'b1000);
        tick();
        chk("fp_drop_data", 16'(fp_out_data), 16'h4);
        chk("fp_drop_sel",  16'(fp_out_sel),  16'h3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised successor to the team's 2:1 combinational data mux: selects among NCH input channels of WIDTH bits each into one output channel.
- Every channel uses a valid/ready handshake, and the output is registered.
- Selection is round-robin or fixed-priority (MODE), with a manual-select override (force_en/force_sel) that reproduces classic select-driven mux behaviour.
- Sits between multiple producers and a single consumer in the datapath.

Parameters:
- WIDTH, 4, data bits per channel
- NCH, 2, number of input channels (>=2)
- MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
- SELW, $clog2(NCH), width of select/index fields (derived, not overridden)

Ports:
- clk        input   1           rising-edge clock
- rst_n      input   1           asynchronous active-low reset
- in_data    input   NCH*WIDTH   channel i at bits [i*WIDTH +: WIDTH]
- in_valid   input   NCH         per-channel valid
- in_ready   output  NCH         per-channel ready (combinational)
- out_data   output  WIDTH       registered output data
- out_valid  output  1           registered output valid
- out_ready  input   1           consumer ready
- out_sel    output  SELW        registered index of channel that sourced out_data
- force_en   input   1           manual select override
- force_sel  input   SELW        channel index used when force_en=1

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, rr pointer=0.
  - in_ready=0 while rst_n low.
  - Reset mid-transfer discards the held item; no partial output.
- load_en = !out_valid || out_ready. The output register accepts a new item when empty or when drained in the same cycle.
- Grant (combinational, one-hot or zero):
  - force_en=1: grant = force_sel, only if in_valid[force_sel]=1 and force_sel<NCH; otherwise no grant.
  - force_en=0, MODE=1: lowest-index valid channel.
  - force_en=0, MODE=0: first valid channel searching ptr, ptr+1, ... NCH-1, 0, ... ptr-1 (wrap-around).
- in_ready[i] = load_en && grant[i]. At most one bit is set.
- Transfer on channel i when in_valid[i] && in_ready[i]. On the next edge: out_data <= channel i data, out_sel <= i, out_valid <= 1.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 item per cycle under continuous out_ready=1.
- If load_en=1 and there is no grant: out_valid <= 0 on the next edge (an item drained this cycle is not replaced). out_data/out_sel hold their last value.
- Backpressure: out_valid=1 and out_ready=0 means out_data/out_sel/out_valid hold and all in_ready=0.
- Round-robin pointer (MODE=0):
  - On a transfer from channel i with force_en=0: ptr <= (i+1) mod NCH.
  - Pointer is unchanged on cycles without a transfer and on forced transfers.
  - With MODE=1 the pointer is unused and stays at 0.
- force_en and force_sel may change any cycle; they take effect on the same-cycle grant. An item already in the output register is unaffected.
- Inputs must hold data stable while valid && !ready (producer rule; not checked by the block).

Test Plan:
- Config WIDTH=4, NCH=4, MODE=0 unless stated.
- Reset: load ch1=4'h7 (out_valid=1, out_ready=0), assert rst_n=0 between edges -> out_valid=0, out_data=0, out_sel=0 immediately. After release, ch3 valid -> ch3 granted first (ptr=0 search).
- Single channel: in_valid=4'b0100, ch2=4'hA, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=4'hA, out_sel=2. Drop in_valid -> out_valid=0 one cycle later.
- Round-robin fairness: all valid, ch0..3 = 5, A, 3, C, out_ready=1 -> out_data sequence 5, A, 3, C, 5, A on consecutive cycles; out_sel 0, 1, 2, 3, 0, 1.
- Backpressure: as above, out_ready=0 for 3 cycles while out_data=A -> out_data=A, out_sel=1 held; in_ready=0. Restore out_ready -> 3 appears next cycle, with no gap and no duplicate.
- Fixed priority (MODE=1): ch1=4'h9 and ch3=4'h4 valid continuously, out_ready=1 -> out_data always 9, out_sel=1; ch3 in_ready never 1. Drop ch1 -> 4 appears the next cycle.
- Force mode: force_en=1, ch0=5, ch3=A (both valid), force_sel toggles 0/3 every 5 cycles -> out_data follows with 1-cycle lag (5...A...). force_sel points at an invalid channel -> out_valid=0 after drain. Clearing force_en -> round-robin resumes from the unchanged ptr.
